// File: rtl/trp_pkg.sv
// Shared types for the transposer job path: descriptor layout, mode encoding,
// sequencer state encoding and the descriptor legality rule.
package trp_pkg;

    localparam int unsigned TRP_AW   = 16;
    localparam int unsigned TRP_ADIM = 6;
    localparam int unsigned TRP_TAGW = 4;

    typedef enum logic [1:0] {
        BIT8_MODE  = 2'b01,
        BIT32_MODE = 2'b10
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LOAD   = 4'b0010,
        S_LAUNCH = 4'b0100,
        S_RUN    = 4'b1000
    } seq_state_t;

    typedef struct packed {
        logic [TRP_TAGW-1:0]              tag;
        logic                             repack_en;
        logic [1:0]                       mode;
        logic [TRP_AW-1:0]                rreq_num;
        logic [TRP_AW-1:0]                wreq_num;
        logic [TRP_AW-1:0]                raddr_base;
        logic [TRP_AW-1:0]                waddr_base;
        logic [TRP_AW-1:0]                packed_dim_size;
        logic [TRP_AW-1:0]                unpacked_dim_size;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]  raddr_size;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]  raddr_stride;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]  waddr_size;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]  waddr_stride;
    } trp_cmd_t;

    // Descriptors the transposer would hang on; these are rejected, never launched.
    function automatic logic cmd_illegal(input trp_cmd_t c);
        logic mode_ok;
        mode_ok = (c.mode == BIT8_MODE) || (c.mode == BIT32_MODE);
        return (c.rreq_num == '0) || (c.wreq_num == '0) ||
               (c.repack_en && !mode_ok) ||
               (c.repack_en && (c.packed_dim_size == '0));
    endfunction

endpackage

// File: rtl/trp_cmd_fifo.sv
// Synchronous descriptor FIFO; full/empty derived from an extra pointer MSB.
module trp_cmd_fifo
    import trp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  trp_cmd_t push_data,
    input  logic     pop,
    output trp_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    trp_cmd_t    mem_q [DEPTH];
    trp_cmd_t    mem_d [DEPTH];
    logic        do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/trp_cmd_seq.sv
// Job sequencer in front of the transposer: queues descriptors, validates each,
// launches one job at a time and reports per-job completion or rejection.
module trp_cmd_seq
    import trp_pkg::*;
#(
    parameter int unsigned AW   = TRP_AW,
    parameter int unsigned ADIM = TRP_ADIM,
    parameter int unsigned QD   = 4,
    parameter int unsigned TAGW = TRP_TAGW,
    parameter int unsigned TMOW = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [TAGW-1:0]           cmd_tag,
    input  logic                      cmd_repack_en,
    input  logic [1:0]                cmd_mode,
    input  logic [AW-1:0]             cmd_rreq_num,
    input  logic [AW-1:0]             cmd_wreq_num,
    input  logic [AW-1:0]             cmd_raddr_base,
    input  logic [AW-1:0]             cmd_waddr_base,
    input  logic [AW-1:0]             cmd_packed_dim_size,
    input  logic [AW-1:0]             cmd_unpacked_dim_size,
    input  logic [ADIM-1:0][AW-1:0]   cmd_raddr_size,
    input  logic [ADIM-1:0][AW-1:0]   cmd_raddr_stride,
    input  logic [ADIM-1:0][AW-1:0]   cmd_waddr_size,
    input  logic [ADIM-1:0][AW-1:0]   cmd_waddr_stride,
    input  logic [TMOW-1:0]           tmo_limit,
    input  logic                      err_clr,
    output logic                      init_pulse,
    output logic                      repack_en,
    output logic [1:0]                mode,
    output logic [AW-1:0]             rreq_num,
    output logic [AW-1:0]             wreq_num,
    output logic [AW-1:0]             raddr_base,
    output logic [AW-1:0]             waddr_base,
    output logic [AW-1:0]             packed_dim_size,
    output logic [AW-1:0]             unpacked_dim_size,
    output logic [ADIM-1:0][AW-1:0]   raddr_size,
    output logic [ADIM-1:0][AW-1:0]   raddr_stride,
    output logic [ADIM-1:0][AW-1:0]   waddr_size,
    output logic [ADIM-1:0][AW-1:0]   waddr_stride,
    input  logic                      finish,
    output logic                      done_vld,
    output logic [TAGW-1:0]           done_tag,
    output logic                      done_err,
    output logic                      busy,
    output logic                      err_ill,
    output logic                      err_tmo,
    output logic                      err_spur
);

    localparam logic [TMOW-1:0] WDOG_ONE = 1;

    seq_state_t      state_q, state_d;
    trp_cmd_t        cmd_in, fifo_head;
    trp_cmd_t        cfg_q, cfg_d;
    logic            fifo_full, fifo_empty;
    logic            pop, launch, load_bad, run_done, wdog_clr, in_run, tmo_hit;
    logic [TMOW-1:0] wdog_q, wdog_d;
    logic            done_vld_q, done_vld_d;
    logic            done_err_q, done_err_d;
    logic [TAGW-1:0] done_tag_q, done_tag_d;
    logic            err_ill_q, err_ill_d;
    logic            err_tmo_q, err_tmo_d;
    logic            err_spur_q, err_spur_d;

    always_comb begin
        cmd_in.tag               = cmd_tag;
        cmd_in.repack_en         = cmd_repack_en;
        cmd_in.mode              = cmd_mode;
        cmd_in.rreq_num          = cmd_rreq_num;
        cmd_in.wreq_num          = cmd_wreq_num;
        cmd_in.raddr_base        = cmd_raddr_base;
        cmd_in.waddr_base        = cmd_waddr_base;
        cmd_in.packed_dim_size   = cmd_packed_dim_size;
        cmd_in.unpacked_dim_size = cmd_unpacked_dim_size;
        cmd_in.raddr_size        = cmd_raddr_size;
        cmd_in.raddr_stride      = cmd_raddr_stride;
        cmd_in.waddr_size        = cmd_waddr_size;
        cmd_in.waddr_stride      = cmd_waddr_stride;
    end

    trp_cmd_fifo #(
        .DEPTH (QD)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_vld),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_LOAD;
            S_LOAD:   state_d = cmd_illegal(cfg_q) ? S_IDLE : S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN:    if (finish) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        launch   = 1'b0;
        load_bad = 1'b0;
        run_done = 1'b0;
        wdog_clr = 1'b0;
        in_run   = 1'b0;
        case (state_q)
            S_IDLE:   pop = !fifo_empty;
            S_LOAD:   load_bad = cmd_illegal(cfg_q);
            S_LAUNCH: begin
                launch   = 1'b1;
                wdog_clr = 1'b1;
            end
            S_RUN: begin
                in_run   = 1'b1;
                run_done = finish;
            end
            default: ;
        endcase
    end

    // Config only moves on pop, so it is stable from S_LOAD through S_RUN.
    always_comb begin
        cfg_d = pop ? fifo_head : cfg_q;

        wdog_d = wdog_q;
        if (wdog_clr) begin
            wdog_d = '0;
        end else if (in_run && (wdog_q != '1)) begin
            wdog_d = wdog_q + WDOG_ONE;
        end
        tmo_hit = in_run && (tmo_limit != '0) && (wdog_d >= tmo_limit);

        done_vld_d = load_bad || run_done;
        done_err_d = load_bad;
        done_tag_d = done_vld_d ? cfg_q.tag : done_tag_q;

        // A new error event in the same cycle as err_clr stays set.
        err_ill_d  = load_bad || (err_ill_q && !err_clr);
        err_tmo_d  = tmo_hit || (err_tmo_q && !err_clr);
        err_spur_d = (finish && !in_run) || (err_spur_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q      <= '0;
            wdog_q     <= '0;
            done_vld_q <= 1'b0;
            done_err_q <= 1'b0;
            done_tag_q <= '0;
            err_ill_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            wdog_q     <= wdog_d;
            done_vld_q <= done_vld_d;
            done_err_q <= done_err_d;
            done_tag_q <= done_tag_d;
            err_ill_q  <= err_ill_d;
            err_tmo_q  <= err_tmo_d;
            err_spur_q <= err_spur_d;
        end
    end

    assign cmd_rdy           = !fifo_full;
    assign busy              = (state_q != S_IDLE) || !fifo_empty;
    assign init_pulse        = launch;
    assign repack_en         = cfg_q.repack_en;
    assign mode              = cfg_q.mode;
    assign rreq_num          = cfg_q.rreq_num;
    assign wreq_num          = cfg_q.wreq_num;
    assign raddr_base        = cfg_q.raddr_base;
    assign waddr_base        = cfg_q.waddr_base;
    assign packed_dim_size   = cfg_q.packed_dim_size;
    assign unpacked_dim_size = cfg_q.unpacked_dim_size;
    assign raddr_size        = cfg_q.raddr_size;
    assign raddr_stride      = cfg_q.raddr_stride;
    assign waddr_size        = cfg_q.waddr_size;
    assign waddr_stride      = cfg_q.waddr_stride;
    assign done_vld          = done_vld_q;
    assign done_err          = done_err_q;
    assign done_tag          = done_tag_q;
    assign err_ill           = err_ill_q;
    assign err_tmo           = err_tmo_q;
    assign err_spur          = err_spur_q;

endmodule

// File: tb/tb_trp_cmd_seq.sv
// Bench for trp_cmd_seq: directed scenarios plus randomized jobs, with a
// scoreboard of expected launches/completions and a simple transposer responder.
module tb_trp_cmd_seq;
    import trp_pkg::*;

    localparam int QD   = 4;
    localparam int TMOW = 20;

    typedef logic [TRP_AW-1:0] aw_t;
    typedef struct {
        logic [TRP_TAGW-1:0] tag;
        logic                err;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    trp_cmd_t        drv = '0;
    logic            cmd_vld = 1'b0;
    logic            err_clr = 1'b0;
    logic            finish = 1'b0;
    logic [TMOW-1:0] tmo_limit = '0;

    logic                             cmd_rdy, init_pulse, repack_en;
    logic [1:0]                       mode;
    aw_t                              rreq_num, wreq_num, raddr_base, waddr_base;
    aw_t                              packed_dim_size, unpacked_dim_size;
    logic [TRP_ADIM-1:0][TRP_AW-1:0]  raddr_size, raddr_stride, waddr_size, waddr_stride;
    logic                             done_vld, done_err, busy, err_ill, err_tmo, err_spur;
    logic [TRP_TAGW-1:0]              done_tag;

    trp_cmd_seq #(
        .AW   (TRP_AW),
        .ADIM (TRP_ADIM),
        .QD   (QD),
        .TAGW (TRP_TAGW),
        .TMOW (TMOW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmd_vld               (cmd_vld),
        .cmd_rdy               (cmd_rdy),
        .cmd_tag               (drv.tag),
        .cmd_repack_en         (drv.repack_en),
        .cmd_mode              (drv.mode),
        .cmd_rreq_num          (drv.rreq_num),
        .cmd_wreq_num          (drv.wreq_num),
        .cmd_raddr_base        (drv.raddr_base),
        .cmd_waddr_base        (drv.waddr_base),
        .cmd_packed_dim_size   (drv.packed_dim_size),
        .cmd_unpacked_dim_size (drv.unpacked_dim_size),
        .cmd_raddr_size        (drv.raddr_size),
        .cmd_raddr_stride      (drv.raddr_stride),
        .cmd_waddr_size        (drv.waddr_size),
        .cmd_waddr_stride      (drv.waddr_stride),
        .tmo_limit             (tmo_limit),
        .err_clr               (err_clr),
        .init_pulse            (init_pulse),
        .repack_en             (repack_en),
        .mode                  (mode),
        .rreq_num              (rreq_num),
        .wreq_num              (wreq_num),
        .raddr_base            (raddr_base),
        .waddr_base            (waddr_base),
        .packed_dim_size       (packed_dim_size),
        .unpacked_dim_size     (unpacked_dim_size),
        .raddr_size            (raddr_size),
        .raddr_stride          (raddr_stride),
        .waddr_size            (waddr_size),
        .waddr_stride          (waddr_stride),
        .finish                (finish),
        .done_vld              (done_vld),
        .done_tag              (done_tag),
        .done_err              (done_err),
        .busy                  (busy),
        .err_ill               (err_ill),
        .err_tmo               (err_tmo),
        .err_spur              (err_spur)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endfunction

    // Legality straight from the descriptor rules.
    function automatic bit model_illegal(input trp_cmd_t c);
        bit mode_ok;
        mode_ok = (c.mode == 2'd1) || (c.mode == 2'd2);
        if (c.rreq_num == 0 || c.wreq_num == 0) return 1'b1;
        if (c.repack_en && (!mode_ok || c.packed_dim_size == 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic trp_cmd_t rand_cmd(input logic [TRP_TAGW-1:0] tag, input bit legal);
        trp_cmd_t c;
        c.tag               = tag;
        c.repack_en         = 1'($urandom_range(0, 1));
        c.mode              = 2'($urandom_range(0, 3));
        c.rreq_num          = aw_t'($urandom);
        c.wreq_num          = aw_t'($urandom);
        c.raddr_base        = aw_t'($urandom);
        c.waddr_base        = aw_t'($urandom);
        c.packed_dim_size   = aw_t'($urandom);
        c.unpacked_dim_size = aw_t'($urandom);
        for (int i = 0; i < TRP_ADIM; i++) begin
            c.raddr_size[i]   = aw_t'($urandom);
            c.raddr_stride[i] = aw_t'($urandom);
            c.waddr_size[i]   = aw_t'($urandom);
            c.waddr_stride[i] = aw_t'($urandom);
        end
        if (legal) begin
            if (c.rreq_num == 0) c.rreq_num = 1;
            if (c.wreq_num == 0) c.wreq_num = 1;
            if (c.repack_en) begin
                c.mode = 2'($urandom_range(1, 2));
                if (c.packed_dim_size == 0) c.packed_dim_size = 7;
            end
        end else begin
            case ($urandom_range(0, 3))
                0: c.rreq_num = 0;
                1: c.wreq_num = 0;
                2: begin c.repack_en = 1'b1; c.mode = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00; end
                default: begin c.repack_en = 1'b1; c.packed_dim_size = 0; end
            endcase
        end
        return c;
    endfunction

    trp_cmd_t  launch_q[$];
    done_exp_t done_q[$];
    int        init_cnt = 0;
    int        done_cnt = 0;

    // Monitor: every launch and every completion is matched against the scoreboard.
    initial begin
        trp_cmd_t  act, exp_c;
        done_exp_t exp_d;
        forever begin
            @(negedge clk);
            if (init_pulse) begin
                init_cnt++;
                if (launch_q.size() == 0) begin
                    fail("launch_expected", "init_pulse with no legal job pending");
                end else begin
                    exp_c = launch_q.pop_front();
                    exp_c.tag = '0;
                    act.tag               = '0;
                    act.repack_en         = repack_en;
                    act.mode              = mode;
                    act.rreq_num          = rreq_num;
                    act.wreq_num          = wreq_num;
                    act.raddr_base        = raddr_base;
                    act.waddr_base        = waddr_base;
                    act.packed_dim_size   = packed_dim_size;
                    act.unpacked_dim_size = unpacked_dim_size;
                    act.raddr_size        = raddr_size;
                    act.raddr_stride      = raddr_stride;
                    act.waddr_size        = waddr_size;
                    act.waddr_stride      = waddr_stride;
                    n_cmp++;
                    if (act !== exp_c) begin
                        n_bad++;
                        $display("FAIL launch_cfg: got %h expected %h", act, exp_c);
                    end
                end
            end
            if (done_vld) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    fail("done_expected", "done_vld with no job outstanding");
                end else begin
                    exp_d = done_q.pop_front();
                    check("done_tag", 64'(done_tag), 64'(exp_d.tag));
                    check("done_err", 64'(done_err), 64'(exp_d.err));
                end
            end
        end
    end

    // Transposer stand-in: finishes a launched job after a delay, or on request.
    bit fin_auto = 1'b0;
    bit fin_rand = 1'b0;
    int fin_delay = 5;
    int kick_req = 0;
    initial begin
        int fin_cnt = 0;
        int kick_seen = 0;
        forever begin
            @(negedge clk);
            finish = 1'b0;
            if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) finish = 1'b1;
            end
            if (init_pulse && fin_auto) begin
                fin_cnt = fin_rand ? int'($urandom_range(1, 6)) : fin_delay;
            end
            if (kick_req != kick_seen) begin
                kick_seen = kick_req;
                finish = 1'b1;
            end
            if (reset) fin_cnt = 0;
        end
    end

    task automatic push_cmd(input trp_cmd_t c, output int unsigned acc_cyc);
        drv = c;
        cmd_vld = 1'b1;
        for (int w = 0; w < 200 && !cmd_rdy; w++) @(negedge clk);
        acc_cyc = cyc;
        if (!cmd_rdy) begin
            fail("cmd_rdy_wait", "descriptor never accepted");
            cmd_vld = 1'b0;
            return;
        end
        if (model_illegal(c)) begin
            done_q.push_back('{c.tag, 1'b1});
        end else begin
            launch_q.push_back(c);
            done_q.push_back('{c.tag, 1'b0});
        end
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int w = 0; w < limit; w++) begin
            if (!busy) return;
            @(negedge clk);
        end
        fail(name, "busy never dropped");
    endtask

    task automatic wait_init(input int limit);
        for (int w = 0; w < limit && !init_pulse; w++) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        trp_cmd_t    c;
        int unsigned acc, l_cyc;
        int          ic, dc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
        check("rst_init", 64'(init_pulse), 64'(0));
        check("rst_done", 64'(done_vld), 64'(0));
        check("rst_errs", 64'({err_ill, err_tmo, err_spur}), 64'(0));
        check("rst_cfg", 64'({repack_en, mode, rreq_num, wreq_num}), 64'(0));

        // 1: single repack job, latency and completion timing
        fin_auto  = 1'b1;
        fin_delay = 20;
        c = rand_cmd(4'd3, 1'b1);
        c.repack_en = 1'b1;
        c.mode      = 2'b01;
        c.rreq_num  = 8;
        push_cmd(c, acc);
        wait_init(20);
        l_cyc = cyc;
        check("t1_init_latency", 64'(l_cyc - acc), 64'(3));
        for (int w = 0; w < 40 && !done_vld; w++) @(negedge clk);
        check("t1_done_latency", 64'(cyc - l_cyc), 64'(21));
        check("t1_busy_drop", 64'(busy), 64'(0));
        @(negedge clk);

        // 2: QD+1 back-to-back jobs with the first one stalled
        fin_auto = 1'b0;
        for (int t = 0; t <= QD; t++) push_cmd(rand_cmd(4'(t), 1'b1), acc);
        check("t2_full_rdy", 64'(cmd_rdy), 64'(0));
        check("t2_busy", 64'(busy), 64'(1));
        fin_auto  = 1'b1;
        fin_delay = 2;
        kick_req++;
        wait_idle("t2_idle", 300);
        @(negedge clk);
        check("t2_rdy_after", 64'(cmd_rdy), 64'(1));

        // 3: illegal descriptor is rejected without launch
        ic = init_cnt;
        dc = done_cnt;
        c = rand_cmd(4'd5, 1'b1);
        c.rreq_num = 0;
        push_cmd(c, acc);
        wait_idle("t3_idle", 50);
        @(negedge clk);
        check("t3_no_init", 64'(init_cnt), 64'(ic));
        check("t3_done_seen", 64'(done_cnt), 64'(dc + 1));
        check("t3_err_ill", 64'(err_ill), 64'(1));
        pulse_err_clr();
        check("t3_err_ill_clr", 64'(err_ill), 64'(0));

        // 4: watchdog fires at RUN cycle 10, job still completes later
        fin_auto  = 1'b0;
        tmo_limit = 10;
        dc = done_cnt;
        push_cmd(rand_cmd(4'd9, 1'b1), acc);
        wait_init(20);
        repeat (10) @(negedge clk);
        check("t4_tmo_early", 64'(err_tmo), 64'(0));
        @(negedge clk);
        check("t4_tmo_set", 64'(err_tmo), 64'(1));
        repeat (5) @(negedge clk);
        check("t4_still_busy", 64'(busy), 64'(1));
        kick_req++;
        wait_idle("t4_idle", 20);
        @(negedge clk);
        check("t4_done_seen", 64'(done_cnt), 64'(dc + 1));
        pulse_err_clr();
        check("t4_tmo_clr", 64'(err_tmo), 64'(0));
        tmo_limit = '0;

        // 5: spurious finish while idle
        dc = done_cnt;
        kick_req++;
        repeat (3) @(negedge clk);
        check("t5_err_spur", 64'(err_spur), 64'(1));
        check("t5_no_done", 64'(done_cnt), 64'(dc));
        pulse_err_clr();
        check("t5_spur_clr", 64'(err_spur), 64'(0));

        // 6: reset during S_RUN with two jobs queued
        fin_auto = 1'b0;
        ic = init_cnt;
        for (int t = 0; t < 3; t++) push_cmd(rand_cmd(4'(10 + t), 1'b1), acc);
        for (int w = 0; w < 20 && init_cnt == ic; w++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t6_busy_pre", 64'(busy), 64'(1));
        reset = 1'b1;
        launch_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        check("t6_rst_outs", 64'({done_vld, init_pulse, busy, err_ill, err_tmo, err_spur}), 64'(0));
        check("t6_rst_cfg", 64'({repack_en, mode, rreq_num, wreq_num, raddr_base}), 64'(0));
        check("t6_rst_rdy", 64'(cmd_rdy), 64'(1));
        reset = 1'b0;
        ic = init_cnt;
        dc = done_cnt;
        repeat (8) @(negedge clk);
        check("t6_queue_empty", 64'(busy), 64'(0));
        check("t6_no_relaunch", 64'(init_cnt), 64'(ic));
        check("t6_no_done", 64'(done_cnt), 64'(dc));

        // 7: randomized mix of legal and illegal jobs with random finish delays
        fin_auto = 1'b1;
        fin_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_cmd(rand_cmd(4'(i), $urandom_range(0, 3) != 0), acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("t7_idle", 2000);
        repeat (2) @(negedge clk);
        check("final_done_q", 64'(done_q.size()), 64'(0));
        check("final_launch_q", 64'(launch_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
